// File: rtl/fifo_feed_scheduler.sv
// Load/drain sequencer for the row FIFOs on the systolic array's left edge.
// Optional macro FEED_PAUSE_EN adds stall_i, which freezes the drain schedule.
module fifo_feed_scheduler #(
    parameter int unsigned Rows  = 4,
    parameter int unsigned Depth = 32,
    parameter int unsigned LenW  = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [LenW-1:0] len_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic [Rows-1:0] fifo_write_o,
    output logic [Rows-1:0] fifo_enable_o,
    input  logic [Rows-1:0] fifo_full_i,
    input  logic [Rows-1:0] fifo_empty_i,
`ifdef FEED_PAUSE_EN
    input  logic            stall_i,
`endif
    output logic [Rows-1:0] row_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o
);

    localparam int unsigned RowW = (Rows > 1) ? $clog2(Rows) : 1;
    localparam int unsigned TW   = $clog2(Depth + Rows) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StFlush, StFin} state_e;

    state_e          state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [LenW-1:0] word_q, word_d;
    logic [LenW-1:0] len_q, len_d;
    logic [TW-1:0]   t_q, t_d;
    logic [Rows-1:0] row_valid_d;
    logic            done_d, error_d;
    logic [Rows-1:0] sched, rd;
    logic [TW-1:0]   last_t;
    logic            stall;

`ifdef FEED_PAUSE_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign last_t = TW'(len_q) + TW'(Rows - 2);
    assign busy_o = (state_q != StIdle);

    // Diagonal skew: row i is read during drain steps i .. i+len-1.
    always_comb begin
        sched = '0;
        for (int unsigned i = 0; i < Rows; i++) begin
            sched[i] = (t_q >= TW'(i)) && (t_q < TW'(i) + TW'(len_q));
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        word_d        = word_q;
        len_d         = len_q;
        t_d           = t_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        in_ready_o    = 1'b0;
        fifo_write_o  = '0;
        fifo_enable_o = '0;
        rd            = '0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i == '0 || 32'(len_i) > Depth || !(&fifo_empty_i)) begin
                        error_d = 1'b1;
                    end else begin
                        len_d   = len_i;
                        row_d   = '0;
                        word_d  = '0;
                        t_d     = '0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                in_ready_o = !fifo_full_i[row_q];
                if (in_valid_i && in_ready_o) begin
                    fifo_write_o[row_q]  = 1'b1;
                    fifo_enable_o[row_q] = 1'b1;
                    if (word_q == len_q - LenW'(1)) begin
                        word_d = '0;
                        if (row_q == RowW'(Rows - 1)) begin
                            t_d     = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + RowW'(1);
                        end
                    end else begin
                        word_d = word_q + LenW'(1);
                    end
                end
            end
            StDrain: begin
                if (!stall) begin
                    rd = sched;
                    if (t_q == last_t) begin
                        state_d = StFlush;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                fifo_enable_o = rd;
                // Underflow is flagged but the read is still issued to keep the skew intact.
                error_d = |(rd & fifo_empty_i);
            end
            StFlush: begin
                done_d  = 1'b1;
                state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        row_valid_d = rd;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            row_q       <= '0;
            word_q      <= '0;
            len_q       <= '0;
            t_q         <= '0;
            row_valid_o <= '0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            word_q      <= word_d;
            len_q       <= len_d;
            t_q         <= t_d;
            row_valid_o <= row_valid_d;
            done_o      <= done_d;
            error_o     <= error_d;
        end
    end

endmodule
